// File: rtl/tt_sel_ctrl.sv
// Single-clock project-select controller for the TinyTapeout mux: synchronises the control pins,
// steps the select counter on edges and holds the spine disabled for a settle window after each change.
module tt_sel_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int N_PROJ      = 1024,
    parameter int WRAP        = 1,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_sel_rst,
    input  logic              ctrl_sel_inc,
    input  logic              ctrl_ena,
    output logic [ADDR_W-1:0] sel,
    output logic              si_ena,
    output logic              proj_rst_n,
    output logic              busy
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [ADDR_W-1:0] MAX_SEL     = ADDR_W'(N_PROJ - 1);
    localparam logic [SW-1:0]     SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_SETTLE,
        S_IDLE,
        S_RUN
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] rst_sync, inc_sync, ena_sync;
    logic                   inc_hist;
    logic                   sel_rst_s, inc_s, ena_s, inc_event;
    logic [SW-1:0]          settle_cnt, settle_next;
    logic [ADDR_W-1:0]      sel_next;
    logic                   sel_event;

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_sync <= '0;
            inc_sync <= '0;
            ena_sync <= '0;
            inc_hist <= 1'b0;
        end else begin
            rst_sync <= {rst_sync[SYNC_STAGES-2:0], ctrl_sel_rst};
            inc_sync <= {inc_sync[SYNC_STAGES-2:0], ctrl_sel_inc};
            ena_sync <= {ena_sync[SYNC_STAGES-2:0], ctrl_ena};
            inc_hist <= inc_s;
        end
    end

    assign sel_rst_s = rst_sync[SYNC_STAGES-1];
    assign inc_s     = inc_sync[SYNC_STAGES-1];
    assign ena_s     = ena_sync[SYNC_STAGES-1];
    assign inc_event = inc_s & ~inc_hist;

    // A clear outranks an increment; a saturating top value swallows the increment without an event.
    always_comb begin
        sel_next  = sel;
        sel_event = 1'b0;
        if (sel_rst_s) begin
            sel_next  = '0;
            sel_event = 1'b1;
        end else if (inc_event) begin
            if (sel != MAX_SEL) begin
                sel_next  = sel + ADDR_W'(1);
                sel_event = 1'b1;
            end else if (WRAP != 0) begin
                sel_next  = '0;
                sel_event = 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state;
        settle_next = settle_cnt;
        case (state)
            S_SETTLE: begin
                if (sel_event) begin
                    settle_next = '0;
                end else if (settle_cnt == SETTLE_LAST) begin
                    settle_next = '0;
                    state_next  = ena_s ? S_RUN : S_IDLE;
                end else begin
                    settle_next = settle_cnt + SW'(1);
                end
            end
            S_IDLE: begin
                if (sel_event) begin
                    state_next  = S_SETTLE;
                    settle_next = '0;
                end else if (ena_s) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (sel_event) begin
                    state_next  = S_SETTLE;
                    settle_next = '0;
                end else if (!ena_s) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next  = S_SETTLE;
                settle_next = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_SETTLE;
            settle_cnt <= '0;
            sel        <= '0;
            si_ena     <= 1'b0;
            proj_rst_n <= 1'b0;
            busy       <= 1'b1;
        end else begin
            state      <= state_next;
            settle_cnt <= settle_next;
            sel        <= sel_next;
            si_ena     <= (state_next == S_RUN);
            proj_rst_n <= (state_next != S_SETTLE);
            busy       <= (state_next == S_SETTLE);
        end
    end

endmodule
